// File: rtl/iter_div_unit_if.sv
// Operand/result handshake bundle for iter_div_unit.
// Both channels are valid/ready: a transfer occurs on a rising edge where valid & ready are both 1.
interface iter_div_unit_if #(
   parameter int DATA_W = 32
);
   logic              div_valid;
   logic              div_ready;
   logic              div_signed;
   logic [DATA_W-1:0] div_src1;
   logic [DATA_W-1:0] div_src2;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_quot;
   logic [DATA_W-1:0] res_rem;

   // Pipeline side: issues operands, consumes results.
   modport master (
      output div_valid, div_signed, div_src1, div_src2, res_ready,
      input  div_ready, res_valid, res_quot, res_rem
   );

   // Divider side.
   modport slave (
      input  div_valid, div_signed, div_src1, div_src2, res_ready,
      output div_ready, res_valid, res_quot, res_rem
   );
endinterface

// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV.W/MOD.W/DIV.WU/MOD.WU) with flush support.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the iterations and returns after one cycle.
module iter_div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   iter_div_unit_if.slave bus,
   output logic [1:0]     dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] dvsr_q, dvsr_d;
   logic [DATA_W-1:0] dvnd_q, dvnd_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic              dz_q, dz_d;
   logic [DATA_W-1:0] res_quot_q, res_quot_d;
   logic [DATA_W-1:0] res_rem_q, res_rem_d;

   logic              sign1, sign2, src2_zero;
   logic [DATA_W-1:0] mag1, mag2;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W-1:0] rem_sub;
   logic              no_borrow;

   // Magnitudes: -0x80000000 wraps to itself, which is the correct unsigned magnitude.
   assign sign1     = bus.div_signed & bus.div_src1[DATA_W-1];
   assign sign2     = bus.div_signed & bus.div_src2[DATA_W-1];
   assign mag1      = sign1 ? -bus.div_src1 : bus.div_src1;
   assign mag2      = sign2 ? -bus.div_src2 : bus.div_src2;
   assign src2_zero = (bus.div_src2 == '0);

   assign rem_sh    = {rem_q, quot_q[DATA_W-1]};
   assign no_borrow = (rem_sh >= {1'b0, dvsr_q});
   assign rem_sub   = rem_sh[DATA_W-1:0] - dvsr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         dvsr_q     <= '0;
         dvnd_q     <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         dz_q       <= 1'b0;
         res_quot_q <= '0;
         res_rem_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         dvsr_q     <= dvsr_d;
         dvnd_q     <= dvnd_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         dz_q       <= dz_d;
         res_quot_q <= res_quot_d;
         res_rem_q  <= res_rem_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      dvsr_d     = dvsr_q;
      dvnd_d     = dvnd_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      dz_d       = dz_q;
      res_quot_d = res_quot_q;
      res_rem_d  = res_rem_q;

      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.div_valid) begin
                  state_d = CALC;
                  cnt_d   = CNT_W'(DATA_W);
                  rem_d   = '0;
                  quot_d  = mag1;
                  dvsr_d  = mag2;
                  dvnd_d  = bus.div_src1;
                  q_neg_d = sign1 ^ sign2;
                  r_neg_d = sign1;
                  dz_d    = src2_zero;
`ifdef DIV_ZERO_BYPASS_EN
                  // Jump straight to the finalize cycle; the forced result is applied there.
                  if (src2_zero) begin
                     cnt_d = '0;
                  end
`endif
               end
            end
            CALC: begin
               if (cnt_q != '0) begin
                  rem_d  = no_borrow ? rem_sub : rem_sh[DATA_W-1:0];
                  quot_d = {quot_q[DATA_W-2:0], no_borrow};
                  cnt_d  = cnt_q - CNT_W'(1);
               end else begin
                  // Finalize cycle: sign fix-up, or the forced divide-by-zero result.
                  state_d = DONE;
                  if (dz_q) begin
                     res_quot_d = '1;
                     res_rem_d  = dvnd_q;
                  end else begin
                     res_quot_d = q_neg_q ? -quot_q : quot_q;
                     res_rem_d  = r_neg_q ? -rem_q : rem_q;
                  end
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.div_ready = (state_q == IDLE);
   assign bus.res_valid = (state_q == DONE);
   assign bus.res_quot  = res_quot_q;
   assign bus.res_rem   = res_rem_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed self-checking bench for iter_div_unit: arithmetic cases, latency, back-pressure,
// flush and mid-operation reset. Honours DIV_ZERO_BYPASS_EN for the zero-divisor latency.
module tb_iter_div_unit;
   localparam int DATA_W   = 32;
   localparam int CNT_W    = 6;
   localparam int FULL_LAT = DATA_W + 1;
`ifdef DIV_ZERO_BYPASS_EN
   localparam int DZ_LAT   = 1;
`else
   localparam int DZ_LAT   = DATA_W + 1;
`endif

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic              flush = 1'b0;
   logic [1:0]        dbg_state;
   int                n_cmp  = 0;
   int                n_fail = 0;
   logic [DATA_W-1:0] exp_q[$];

   iter_div_unit_if #(.DATA_W(DATA_W)) dif ();

   iter_div_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .bus         (dif),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one operand pair, then counts rising edges from the accepting edge until res_valid.
   task automatic issue_wait(input string tag, input logic sgn, input logic [DATA_W-1:0] a,
                             input logic [DATA_W-1:0] b, input int exp_lat);
      int lat;
      int busy_bad;
      @(negedge clk);
      check({tag, " ready_idle"}, DATA_W'(dif.div_ready), 1);
      dif.div_valid  = 1'b1;
      dif.div_signed = sgn;
      dif.div_src1   = a;
      dif.div_src2   = b;
      @(posedge clk);
      lat      = 0;
      busy_bad = 0;
      @(negedge clk);
      dif.div_valid = 1'b0;
      while (!dif.res_valid && lat < 100) begin
         if (dif.div_ready) busy_bad++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, " latency"}, DATA_W'(lat), DATA_W'(exp_lat));
      check({tag, " ready_busy"}, DATA_W'(busy_bad), 0);
   endtask

   // Holds res_ready low for 'hold' cycles with a competing request, then hands off.
   task automatic handoff(input string tag, input int hold, input logic [DATA_W-1:0] eq,
                          input logic [DATA_W-1:0] er);
      int unstable;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         dif.div_valid  = 1'b1;
         dif.div_signed = 1'b0;
         dif.div_src1   = DATA_W'($urandom_range(1, 1000));
         dif.div_src2   = DATA_W'($urandom_range(1, 9));
         @(posedge clk);
         @(negedge clk);
         if (!dif.res_valid || dif.div_ready || dif.res_quot !== eq || dif.res_rem !== er)
            unstable++;
      end
      if (hold > 0) check({tag, " hold_stable"}, DATA_W'(unstable), 0);
      dif.div_valid = 1'b0;
      dif.res_ready = 1'b1;
      check({tag, " ready_at_handoff"}, DATA_W'(dif.div_ready), 0);
      @(posedge clk);
      @(negedge clk);
      dif.res_ready = 1'b0;
      check({tag, " valid_after"}, DATA_W'(dif.res_valid), 0);
      check({tag, " ready_after"}, DATA_W'(dif.div_ready), 1);
   endtask

   task automatic run_op(input string tag, input logic sgn, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] eq,
                         input logic [DATA_W-1:0] er, input int lat, input int hold);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      issue_wait(tag, sgn, a, b, lat);
      check({tag, " quot"}, dif.res_quot, exp_q.pop_front());
      check({tag, " rem"}, dif.res_rem, exp_q.pop_front());
      handoff(tag, hold, eq, er);
   endtask

   initial begin
      int rv_seen;
      dif.div_valid  = 1'b0;
      dif.div_signed = 1'b0;
      dif.div_src1   = '0;
      dif.div_src2   = '0;
      dif.res_ready  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst div_ready", DATA_W'(dif.div_ready), 1);
      check("rst res_valid", DATA_W'(dif.res_valid), 0);
      check("rst res_quot", dif.res_quot, 0);
      check("rst res_rem", dif.res_rem, 0);
      check("rst state", DATA_W'(dbg_state), 0);

      // Arithmetic cases
      run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, FULL_LAT, 0);
      run_op("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, FULL_LAT, 0);
      run_op("sm100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, FULL_LAT, 0);
      run_op("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, FULL_LAT, 0);
      run_op("uFF9C_7", 1'b0, 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, FULL_LAT, 0);
      run_op("uFFFF_2", 1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, FULL_LAT, 0);
      run_op("u7_100", 1'b0, 32'd7, 32'd100, 32'd0, 32'd7, FULL_LAT, 0);
      run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, FULL_LAT, 0);
      run_op("s_min_1", 1'b1, 32'h80000000, 32'd1, 32'h80000000, 32'd0, FULL_LAT, 0);

      // Divide by zero, unsigned and signed
      run_op("dz_u", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, DZ_LAT, 0);
      run_op("dz_s", 1'b1, 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF9C, DZ_LAT, 0);

      // Back-pressure: result held for 5 cycles with a competing request
      run_op("bp", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, FULL_LAT, 5);

      // Flush during CALC together with a new request
      @(negedge clk);
      dif.div_valid  = 1'b1;
      dif.div_signed = 1'b0;
      dif.div_src1   = 32'd1000;
      dif.div_src2   = 32'd3;
      @(posedge clk);
      @(negedge clk);
      dif.div_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("fl in_calc", DATA_W'(dbg_state), 1);
      flush          = 1'b1;
      dif.div_valid  = 1'b1;
      dif.div_src1   = 32'd5;
      dif.div_src2   = 32'd1;
      @(posedge clk);
      @(negedge clk);
      flush         = 1'b0;
      dif.div_valid = 1'b0;
      check("fl state", DATA_W'(dbg_state), 0);
      check("fl div_ready", DATA_W'(dif.div_ready), 1);
      check("fl res_valid", DATA_W'(dif.res_valid), 0);

      // Flush in IDLE beats a simultaneous accept
      flush          = 1'b1;
      dif.div_valid  = 1'b1;
      dif.div_src1   = 32'd50;
      dif.div_src2   = 32'd5;
      @(posedge clk);
      @(negedge clk);
      flush         = 1'b0;
      dif.div_valid = 1'b0;
      check("fl idle state", DATA_W'(dbg_state), 0);
      check("fl idle ready", DATA_W'(dif.div_ready), 1);

      rv_seen = 0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (dif.res_valid) rv_seen++;
      end
      check("fl no_result", DATA_W'(rv_seen), 0);
      run_op("fl 9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, FULL_LAT, 0);

      // Reset while a result is waiting in DONE
      exp_q.push_back(32'd14);
      issue_wait("rst_mid", 1'b0, 32'd100, 32'd7, FULL_LAT);
      check("rst_mid quot", dif.res_quot, exp_q.pop_front());
      check("rst_mid valid_before", DATA_W'(dif.res_valid), 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid res_valid", DATA_W'(dif.res_valid), 0);
      check("rst_mid div_ready", DATA_W'(dif.div_ready), 1);
      check("rst_mid res_quot", dif.res_quot, 0);
      check("rst_mid res_rem", dif.res_rem, 0);

      run_op("post_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, FULL_LAT, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
